// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_prefetch_buffer : fetch stage with a single-outstanding memory port,
// a small {PC, instruction} prefetch FIFO and the IF/ID pipeline register.
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        PCSrcE,
   input  logic [31:0] PCTarget,
   input  logic        stall,
   output logic [31:0] IF_ID_IR,
   output logic [31:0] IF_ID_PC,
   output logic        IF_ID_valid
);

   localparam int          PW  = $clog2(DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_ir [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fetch_pc;
   logic          outstanding;
   logic          discard;

   logic          ack_ok;
   logic          pop;
   logic          push;
   logic          still_pending;
   logic          issue;
   logic [CW-1:0] count_nx;
   logic [31:0]   fetch_pc_nx;
   logic          discard_nx;

   // Acks with nothing in flight (e.g. straggling across a reset) are ignored.
   assign ack_ok        = imem_ack & outstanding;
   assign pop           = ~PCSrcE & ~stall & (count != '0);
   assign push          = ack_ok & ~discard & ~PCSrcE;
   assign still_pending = outstanding & ~ack_ok;
   assign count_nx      = PCSrcE ? '0 : (count + CW'(push) - CW'(pop));
   assign issue         = ~still_pending & (count_nx < CW'(DEPTH));
   assign discard_nx    = PCSrcE ? still_pending : (discard & ~ack_ok);

   always_comb begin
      fetch_pc_nx = fetch_pc;
      if (PCSrcE)
         fetch_pc_nx = PCTarget & 32'hFFFF_FFFC;
      else if (push)
         fetch_pc_nx = imem_addr + 32'd4;
   end

   assign imem_req = outstanding;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr] <= imem_addr;
         fifo_ir[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding <= 1'b0;
         imem_addr   <= RESET_PC;
         fetch_pc    <= RESET_PC;
         discard     <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         IF_ID_IR    <= NOP;
         IF_ID_PC    <= 32'h0000_0000;
         IF_ID_valid <= 1'b0;
      end else begin
         // A request redirected away stays on the bus at its old address.
         outstanding <= still_pending | issue;
         if (issue)
            imem_addr <= fetch_pc_nx;
         fetch_pc <= fetch_pc_nx;
         discard  <= discard_nx;
         count    <= count_nx;
         rd_ptr   <= PCSrcE ? '0 : rd_ptr + PW'(pop);
         wr_ptr   <= PCSrcE ? '0 : wr_ptr + PW'(push);

         if (PCSrcE) begin
            IF_ID_IR    <= NOP;
            IF_ID_valid <= 1'b0;
         end else if (!stall) begin
            if (pop) begin
               IF_ID_IR    <= fifo_ir[rd_ptr];
               IF_ID_PC    <= fifo_pc[rd_ptr];
               IF_ID_valid <= 1'b1;
            end else begin
               IF_ID_IR    <= NOP;
               IF_ID_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_buffer : randomized memory latency, stalls and redirects
// against a queue-level model of the fetch stage.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        PCSrcE;
   logic [31:0] PCTarget;
   logic        stall;
   logic [31:0] IF_ID_IR;
   logic [31:0] IF_ID_PC;
   logic        IF_ID_valid;

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .PCSrcE(PCSrcE), .PCTarget(PCTarget), .stall(stall),
      .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC), .IF_ID_valid(IF_ID_valid)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_deliv = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: responds after `cur_lat` wait cycles; can inject one stray ack.
   int lat = 0;
   int rand_lat = 0;
   int cur_lat = 0;
   int waitc = 0;
   int stray_req = 0;
   int stray_done = 0;

   always @(negedge clk) begin
      if (stray_req != stray_done) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         stray_done = stray_req;
      end else if (!rst || !imem_req) begin
         imem_ack = 1'b0;
         waitc    = 0;
      end else if (waitc >= cur_lat) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_data(imem_addr);
         waitc      = 0;
         cur_lat    = (rand_lat != 0) ? int'($urandom_range(0, 3)) : lat;
      end else begin
         imem_ack = 1'b0;
         waitc++;
      end
   end

   // Reference model: queue of fetched {pc, word}, one in-flight request.
   logic [63:0] q[$];
   logic [63:0] ent;
   logic        m_req, m_disc, m_v, pending, acc;
   logic [31:0] m_addr, m_pc, m_ir, m_pcid;
   logic        s_ack, s_st, s_rd;
   logic [31:0] s_rdata, s_tgt;

   always @(posedge clk) begin
      if (!rst) begin
         q.delete();
         m_req  = 1'b0;  m_disc = 1'b0;  m_v = 1'b0;
         m_addr = RESET_PC;  m_pc = RESET_PC;
         m_ir   = NOP;  m_pcid = 32'h0;
      end else begin
         s_ack = imem_ack;  s_rdata = imem_rdata;
         s_st  = stall;     s_rd = PCSrcE;  s_tgt = PCTarget;
         acc   = m_req && s_ack;
         if (s_rd) begin
            q.delete();
            m_v  = 1'b0;
            m_ir = NOP;
         end else if (!s_st) begin
            if (q.size() > 0) begin
               ent    = q.pop_front();
               m_v    = 1'b1;
               m_pcid = ent[63:32];
               m_ir   = ent[31:0];
               n_deliv++;
            end else begin
               m_v  = 1'b0;
               m_ir = NOP;
            end
         end
         if (acc && !m_disc && !s_rd) begin
            q.push_back({m_addr, s_rdata});
            m_pc = m_addr + 32'd4;
         end
         if (s_rd) m_pc = {s_tgt[31:2], 2'b00};
         pending = m_req && !acc;
         m_disc  = s_rd ? pending : (m_disc && !acc);
         m_req   = pending || (q.size() < DEPTH);
         if (!pending) m_addr = m_pc;
         #1;
         chk("imem_req", imem_req, m_req);
         if (m_req) chk("imem_addr", imem_addr, m_addr);
         chk("if_id_valid", IF_ID_valid, m_v);
         chk("if_id_ir", IF_ID_IR, m_ir);
         if (m_v) chk("if_id_pc", IF_ID_PC, m_pcid);
         chk("fifo_bound", (q.size() <= DEPTH), 1'b1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, imem_req, 1'b0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
      chk({tag, "_ir"}, IF_ID_IR, NOP);
      chk({tag, "_pc"}, IF_ID_PC, 32'h0);
      chk({tag, "_valid"}, IF_ID_valid, 1'b0);
   endtask

   initial begin
      logic [31:0] held_pc, held_ir;
      int t;
      rst = 1'b0;  stall = 1'b0;  PCSrcE = 1'b0;  PCTarget = 32'h0;
      imem_ack = 1'b0;  imem_rdata = 32'h0;
      cyc(2);
      chk_reset_outputs("reset");

      // Zero-wait streaming from reset.
      rst = 1'b1;
      cyc(1);
      chk("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, RESET_PC);
      cyc(2);
      chk("first_valid", IF_ID_valid, 1'b1);
      chk("first_pc", IF_ID_PC, 32'h0);
      cyc(1);
      chk("second_pc", IF_ID_PC, 32'h4);
      cyc(10);
      chk("stream_rate", (n_deliv >= 10), 1'b1);

      // Long stall fills the FIFO, then drains in order.
      stall = 1'b1;
      held_pc = IF_ID_PC;  held_ir = IF_ID_IR;
      cyc(10);
      chk("stall_req_low", imem_req, 1'b0);
      chk("stall_hold_pc", IF_ID_PC, held_pc);
      chk("stall_hold_ir", IF_ID_IR, held_ir);
      stall = 1'b0;
      cyc(8);

      // Random latency with random stalls.
      rand_lat = 1;
      repeat (40) begin
         stall = ($urandom % 4 == 0);
         cyc(1);
      end
      stall = 1'b0;

      // Redirect while a slow request to 0x10 is pending.
      rand_lat = 0;  lat = 3;
      PCSrcE = 1'b1;  PCTarget = 32'h0;
      cyc(1);
      PCSrcE = 1'b0;
      t = 0;
      while (!(imem_req && imem_addr == 32'h10) && t < 200) begin
         cyc(1);
         t++;
      end
      chk("reach_0x10", (t < 200), 1'b1);
      PCSrcE = 1'b1;  PCTarget = 32'h0000_0102;
      cyc(1);
      PCSrcE = 1'b0;
      chk("discard_req_held", imem_req, 1'b1);
      chk("discard_addr_held", imem_addr, 32'h10);
      t = 0;
      while (!IF_ID_valid && t < 100) begin
         cyc(1);
         t++;
      end
      chk("redirect_first_pc", IF_ID_PC, 32'h0000_0100);

      // Redirect coinciding with an ack (zero-wait memory).
      lat = 0;
      cyc(8);
      PCSrcE = 1'b1;  PCTarget = $urandom & 32'h0FFF_FFFC;
      cyc(1);
      PCSrcE = 1'b0;
      chk("coincide_req", imem_req, 1'b1);
      chk("coincide_addr", imem_addr, PCTarget);
      cyc(6);

      // Redirect under stall with a full FIFO.
      stall = 1'b1;
      cyc(8);
      chk("full_req_low", imem_req, 1'b0);
      PCSrcE = 1'b1;  PCTarget = 32'h0000_2000;
      cyc(1);
      PCSrcE = 1'b0;
      chk("flush_valid", IF_ID_valid, 1'b0);
      chk("flush_ir", IF_ID_IR, NOP);
      chk("flush_addr", imem_addr, 32'h0000_2000);
      stall = 1'b0;
      cyc(5);

      // Fetch PC wrap.
      PCSrcE = 1'b1;  PCTarget = 32'hFFFF_FFFE;
      cyc(1);
      PCSrcE = 1'b0;
      chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      cyc(1);
      chk("wrap_addr_zero", imem_addr, 32'h0);
      cyc(4);

      // Soak: random latency, stalls and redirects.
      rand_lat = 1;
      repeat (300) begin
         stall = ($urandom % 3 == 0);
         if ($urandom % 25 == 0) begin
            PCSrcE = 1'b1;
            PCTarget = $urandom;
         end else begin
            PCSrcE = 1'b0;
         end
         cyc(1);
      end
      PCSrcE = 1'b0;  stall = 1'b0;

      // Reset mid-wait, then a stray ack right after release.
      rand_lat = 0;  lat = 3;
      cyc(6);
      t = 0;
      while (!imem_req && t < 20) begin
         cyc(1);
         t++;
      end
      chk("midwait_req", imem_req, 1'b1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      cyc(2);
      stray_req++;
      rst = 1'b1;
      cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
